// File: rtl/work_transmit_pkg.sv
// Shared constants, FSM encoding and helpers for the work frame transmitter.
package work_transmit_pkg;

   localparam int unsigned FRAME_BYTES                = 64;
   localparam int unsigned DEFAULT_COMM_CLK_FREQUENCY = 109_000_000;
   localparam int unsigned DEFAULT_BAUD_RATE          = 115_200;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_START    = 3'd2,
      ST_HOLD     = 3'd3,
      ST_GAP      = 3'd4,
      ST_DONE     = 3'd5
   } tx_state_e;

   // Byte counter increment that sticks at the frame length instead of wrapping.
   function automatic logic [6:0] sat_inc(input logic [6:0] value, input logic [6:0] limit);
      if (value < limit) begin
         sat_inc = value + 7'd1;
      end else begin
         sat_inc = value;
      end
   endfunction

endpackage

// File: rtl/work_transmit_if.sv
// Work frame request/status bundle between a frame producer and work_transmit.
interface work_transmit_if;
   import work_transmit_pkg::*;

   logic [255:0] midstate;
   logic [255:0] data2;
   logic         send;
   logic         busy;
   logic         tx_done;
   logic         TxD;

   modport master (output midstate, data2, send, input busy, tx_done, TxD);
   modport slave  (input midstate, data2, send, output busy, tx_done, TxD);

endinterface

// File: rtl/work_transmit_uart.sv
// 8N1 UART transmitter: LSB first, idle high, tx_ready high when a new byte can be taken.
module uart_transmitter
   import work_transmit_pkg::*;
#(
   parameter int unsigned comm_clk_frequency = DEFAULT_COMM_CLK_FREQUENCY,
   parameter int unsigned baud_rate          = DEFAULT_BAUD_RATE
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       uart_tx,
   input  logic       rx_new_byte,
   input  logic [7:0] rx_byte,
   output logic       tx_ready
);

   localparam int unsigned DIV = (comm_clk_frequency / baud_rate > 0) ?
                                 (comm_clk_frequency / baud_rate) : 1;

   logic [9:0]  shift_r;
   logic [3:0]  bit_r;
   logic [31:0] div_r;
   logic        ready_r;
   logic        tx_r;

   // Serialiser: start bit, 8 data bits, stop bit, each DIV clocks long.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= 10'h3FF;
         bit_r   <= 4'd0;
         div_r   <= 32'd0;
         ready_r <= 1'b1;
         tx_r    <= 1'b1;
      end else if (ready_r) begin
         tx_r <= 1'b1;
         if (rx_new_byte) begin
            shift_r <= {1'b1, rx_byte, 1'b0};
            bit_r   <= 4'd0;
            div_r   <= 32'd0;
            ready_r <= 1'b0;
         end
      end else begin
         tx_r <= shift_r[0];
         if (div_r == DIV - 32'd1) begin
            div_r   <= 32'd0;
            shift_r <= {1'b1, shift_r[9:1]};
            if (bit_r == 4'd9) begin
               ready_r <= 1'b1;
            end else begin
               bit_r <= bit_r + 4'd1;
            end
         end else begin
            div_r <= div_r + 32'd1;
         end
      end
   end

   assign uart_tx  = tx_r;
   assign tx_ready = ready_r;

endmodule

// File: rtl/work_transmit.sv
// Sends {midstate, data2} as 64 UART bytes, MSB first, with an idle gap after each byte.
// Optional feature macro: CONFIG_TX_CHECKSUM_EN appends an XOR checksum byte.
module work_transmit
   import work_transmit_pkg::*;
#(
   parameter int unsigned comm_clk_frequency = DEFAULT_COMM_CLK_FREQUENCY,
   parameter int unsigned GAP_CYCLES         = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   work_transmit_if.slave bus
);

`ifdef CONFIG_TX_CHECKSUM_EN
   localparam logic [6:0] FRAME_LEN = 7'(FRAME_BYTES + 1);
`else
   localparam logic [6:0] FRAME_LEN = 7'(FRAME_BYTES);
`endif

   tx_state_e    state_r;
   tx_state_e    state_n;
   tx_state_e    decide_s;
   logic [511:0] buffer_r;
   logic [6:0]   count_r;
   logic [31:0]  gap_r;
   logic         busy_r;
   logic         tx_done_r;
   logic         start_s;
   logic         accept_s;
   logic         tx_ready_s;
   logic         uart_tx_s;
   logic [7:0]   byte_s;

   assign accept_s = (state_r == ST_IDLE) && bus.send;
   assign decide_s = (count_r < FRAME_LEN) ? ST_WAIT_RDY : ST_DONE;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic; the start strobe is additionally gated by tx_ready.
   always_comb begin
      state_n = state_r;
      start_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.send) state_n = ST_WAIT_RDY;
            else          state_n = ST_IDLE;
         end
         ST_WAIT_RDY: begin
            if (tx_ready_s) state_n = ST_START;
            else            state_n = ST_WAIT_RDY;
         end
         ST_START: begin
            start_s = tx_ready_s;
            state_n = ST_HOLD;
         end
         ST_HOLD: begin
            if (!tx_ready_s)               state_n = ST_HOLD;
            else if (GAP_CYCLES == 32'd0)  state_n = decide_s;
            else                           state_n = ST_GAP;
         end
         ST_GAP: begin
            if (gap_r == GAP_CYCLES - 32'd1) state_n = decide_s;
            else                             state_n = ST_GAP;
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Frame buffer, byte counter, gap timer and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buffer_r  <= 512'd0;
         count_r   <= 7'd0;
         gap_r     <= 32'd0;
         busy_r    <= 1'b0;
         tx_done_r <= 1'b0;
      end else begin
         busy_r    <= (state_n == ST_WAIT_RDY) || (state_n == ST_START) ||
                      (state_n == ST_HOLD) || (state_n == ST_GAP);
         tx_done_r <= (state_n == ST_DONE);
         if (accept_s) begin
            buffer_r <= {bus.midstate, bus.data2};
            count_r  <= 7'd0;
         end else if (start_s) begin
            buffer_r <= {buffer_r[503:0], 8'h00};
            count_r  <= sat_inc(count_r, FRAME_LEN);
         end
         if (state_r == ST_GAP) gap_r <= gap_r + 32'd1;
         else                   gap_r <= 32'd0;
      end
   end

`ifdef CONFIG_TX_CHECKSUM_EN
   logic [7:0] csum_r;

   // XOR of every frame byte handed to the UART; sent once the 64 data bytes are out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_r <= 8'h00;
      end else if (accept_s) begin
         csum_r <= 8'h00;
      end else if (start_s && (count_r < 7'(FRAME_BYTES))) begin
         csum_r <= csum_r ^ buffer_r[511:504];
      end
   end

   assign byte_s = (count_r == 7'(FRAME_BYTES)) ? csum_r : buffer_r[511:504];
`else
   assign byte_s = buffer_r[511:504];
`endif

   uart_transmitter #(
      .comm_clk_frequency(comm_clk_frequency)
   ) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_tx    (uart_tx_s),
      .rx_new_byte(start_s),
      .rx_byte    (byte_s),
      .tx_ready   (tx_ready_s)
   );

   assign bus.busy    = busy_r;
   assign bus.tx_done = tx_done_r;
   assign bus.TxD     = uart_tx_s;

endmodule

// File: tb/tb_work_transmit.sv
// Bench for work_transmit: three instances (gap 16, 0, 100) with UART line decoders.
module tb_work_transmit;
   import work_transmit_pkg::*;

   localparam int unsigned CLK_HZ = 460_800;   // 4 clocks per bit at 115200 baud
   localparam int BUDGET   = 6000;
   localparam int BUDGET_H = 12000;
`ifdef CONFIG_TX_CHECKSUM_EN
   localparam int FL = 65;
`else
   localparam int FL = 64;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   work_transmit_if bus_a ();
   work_transmit_if bus_z ();
   work_transmit_if bus_h ();

   work_transmit #(.comm_clk_frequency(CLK_HZ), .GAP_CYCLES(16))  dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   work_transmit #(.comm_clk_frequency(CLK_HZ), .GAP_CYCLES(0))   dut_z (.clk(clk), .rst_n(rst_n), .bus(bus_z));
   work_transmit #(.comm_clk_frequency(CLK_HZ), .GAP_CYCLES(100)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bus_h));

   logic txd_l  [3];
   logic busy_l [3];
   logic done_l [3];
   assign txd_l[0] = bus_a.TxD;     assign txd_l[1] = bus_z.TxD;     assign txd_l[2] = bus_h.TxD;
   assign busy_l[0] = bus_a.busy;   assign busy_l[1] = bus_z.busy;   assign busy_l[2] = bus_h.busy;
   assign done_l[0] = bus_a.tx_done; assign done_l[1] = bus_z.tx_done; assign done_l[2] = bus_h.tx_done;

   // Line decoders: start bit found on a low sample, data sampled mid-bit, partial bytes dropped on reset.
   for (genvar g = 0; g < 3; g++) begin : g_mon
      logic [7:0] mem [0:1023];
      logic [7:0] sh       = 8'h00;
      logic       active   = 1'b0;
      int         tick     = 0;
      int         cnt      = 0;
      int         idle     = 0;
      int         min_idle = 1000000;
      int         ferr     = 0;
      always @(negedge clk) begin
         if (!rst_n) begin
            active <= 1'b0;
            tick   <= 0;
            idle   <= 0;
         end else if (!active) begin
            if (txd_l[g] == 1'b0) begin
               active <= 1'b1;
               tick   <= 1;
               if (cnt > 0 && idle < min_idle) min_idle <= idle;
            end else begin
               idle <= idle + 1;
            end
         end else begin
            tick <= tick + 1;
            if (tick >= 6 && tick <= 34 && (tick % 4) == 2) sh <= {txd_l[g], sh[7:1]};
            if (tick == 38) begin
               if (txd_l[g] != 1'b1) ferr <= ferr + 1;
               mem[10'(cnt)] <= sh;
               cnt <= cnt + 1;
            end
            if (tick == 39) begin
               active <= 1'b0;
               idle   <= 0;
            end
         end
      end
   end

   function automatic int mon_cnt(input int lane);
      case (lane)
         0:       return g_mon[0].cnt;
         1:       return g_mon[1].cnt;
         default: return g_mon[2].cnt;
      endcase
   endfunction

   function automatic logic [7:0] mon_byte(input int lane, input int idx);
      case (lane)
         0:       return g_mon[0].mem[10'(idx)];
         1:       return g_mon[1].mem[10'(idx)];
         default: return g_mon[2].mem[10'(idx)];
      endcase
   endfunction

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input int lane, input logic [255:0] ms, input logic [255:0] d2, input logic s);
      case (lane)
         0:       begin bus_a.midstate = ms; bus_a.data2 = d2; bus_a.send = s; end
         1:       begin bus_z.midstate = ms; bus_z.data2 = d2; bus_z.send = s; end
         default: begin bus_h.midstate = ms; bus_h.data2 = d2; bus_h.send = s; end
      endcase
   endtask

   task automatic start_frame(input int lane, input logic [255:0] ms, input logic [255:0] d2);
      @(negedge clk);
      drive(lane, ms, d2, 1'b1);
      @(negedge clk);
      check("busy_after_send", longint'(busy_l[lane]), 1);
      drive(lane, ms, d2, 1'b0);
   endtask

   task automatic wait_done(input int lane, input int budget, output int n);
      n = 0;
      for (int c = 0; c < budget && n == 0; c++) begin
         @(negedge clk);
         if (done_l[lane]) n++;
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done_l[lane]) n++;
      end
   endtask

   // Reference frame model: bytes of {ms, d2} MSB first, plus XOR byte when enabled.
   task automatic check_frame(input string name, input int lane, input int base,
                              input logic [255:0] ms, input logic [255:0] d2);
      logic [511:0] f;
      logic [7:0]   e;
      logic [7:0]   cs;
      int           bad;
      f   = {ms, d2};
      cs  = 8'h00;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         e  = f[511:504];
         f  = f << 8;
         cs = cs ^ e;
         if (mon_byte(lane, base + i) !== e) bad++;
      end
`ifdef CONFIG_TX_CHECKSUM_EN
      if (mon_byte(lane, base + 64) !== cs) bad++;
`endif
      check({name, "_bad_bytes"}, bad, 0);
   endtask

   typedef struct {
      logic [255:0] ms;
      logic [255:0] d2;
      logic [7:0]   b0, b31, b32, b63, cs;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int base;
      int n;
      int bad;
      vecs[0] = '{256'h1, {256{1'b1}}, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'h01};
      vecs[1] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f,
                  8'h00, 8'h1F, 8'h20, 8'h3F, 8'h00};
      vecs[2] = '{{8'hA5, 248'h0}, 256'h0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'hA5};
      vecs[3] = '{{32'hDEADBEEF, 224'h0}, {224'h0, 32'hCAFEF00D}, 8'hDE, 8'h00, 8'h00, 8'h0D, 8'hEB};

      for (int l = 0; l < 3; l++) drive(l, 256'h0, 256'h0, 1'b0);
      repeat (4) @(negedge clk);
      check("reset_busy",    longint'(busy_l[0]), 0);
      check("reset_tx_done", longint'(done_l[0]), 0);
      check("reset_txd_a",   longint'(txd_l[0]), 1);
      check("reset_txd_h",   longint'(txd_l[2]), 1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Table-driven frames on the gap-16 instance.
      for (int v = 0; v < 4; v++) begin
         base = mon_cnt(0);
         start_frame(0, vecs[v].ms, vecs[v].d2);
         wait_done(0, BUDGET, n);
         check("vec_done_pulses", n, 1);
         check("vec_busy_after",  longint'(busy_l[0]), 0);
         check("vec_byte_count",  mon_cnt(0) - base, FL);
         check("vec_byte0",  longint'(mon_byte(0, base)),      longint'(vecs[v].b0));
         check("vec_byte31", longint'(mon_byte(0, base + 31)), longint'(vecs[v].b31));
         check("vec_byte32", longint'(mon_byte(0, base + 32)), longint'(vecs[v].b32));
         check("vec_byte63", longint'(mon_byte(0, base + 63)), longint'(vecs[v].b63));
`ifdef CONFIG_TX_CHECKSUM_EN
         check("vec_checksum", longint'(mon_byte(0, base + 64)), longint'(vecs[v].cs));
`endif
         check_frame("vec", 0, base, vecs[v].ms, vecs[v].d2);
      end
      check("gap16_min_idle_ok", longint'(g_mon[0].min_idle >= 16), 1);

      // send held high: three back-to-back frames.
      base = mon_cnt(0);
      n = 0;
      @(negedge clk);
      drive(0, vecs[3].ms, vecs[3].d2, 1'b1);
      for (int c = 0; c < 3 * BUDGET && n < 3; c++) begin
         @(negedge clk);
         if (done_l[0]) begin
            n++;
            if (n == 3) drive(0, vecs[3].ms, vecs[3].d2, 1'b0);
         end
      end
      drive(0, vecs[3].ms, vecs[3].d2, 1'b0);
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (done_l[0]) n++;
      end
      check("held_done_pulses", n, 3);
      check("held_busy_after",  longint'(busy_l[0]), 0);
      check("held_byte_count",  mon_cnt(0) - base, 3 * FL);
      for (int k = 0; k < 3; k++) check_frame("held", 0, base + k * FL, vecs[3].ms, vecs[3].d2);

      // Second send and input change at byte 10 must not disturb the frame.
      base = mon_cnt(0);
      start_frame(0, vecs[1].ms, vecs[1].d2);
      for (int c = 0; c < BUDGET && mon_cnt(0) < base + 10; c++) @(negedge clk);
      check("midframe_reached_10", longint'(mon_cnt(0) >= base + 10), 1);
      drive(0, ~vecs[1].ms, vecs[1].ms, 1'b1);
      @(negedge clk);
      drive(0, ~vecs[1].ms, vecs[1].ms, 1'b0);
      wait_done(0, BUDGET, n);
      repeat (200) @(negedge clk);
      check("midframe_done_pulses", n, 1);
      check("midframe_byte_count",  mon_cnt(0) - base, FL);
      check("midframe_busy_after",  longint'(busy_l[0]), 0);
      check_frame("midframe", 0, base, vecs[1].ms, vecs[1].d2);

      // Reset during byte 21 aborts the frame.
      base = mon_cnt(0);
      start_frame(0, vecs[0].ms, vecs[0].d2);
      for (int c = 0; c < BUDGET && mon_cnt(0) < base + 20; c++) @(negedge clk);
      check("reset_reached_20", longint'(mon_cnt(0) >= base + 20), 1);
      repeat (25) @(negedge clk);
      rst_n = 1'b0;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (txd_l[0] !== 1'b1 || busy_l[0] !== 1'b0 || done_l[0] !== 1'b0) bad++;
      end
      check("in_reset_outputs_bad", bad, 0);
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (done_l[0] || busy_l[0]) n++;
      end
      check("after_reset_activity", n, 0);
      check("after_reset_bytes",    mon_cnt(0) - base, 20);
      base = mon_cnt(0);
      start_frame(0, vecs[1].ms, vecs[1].d2);
      wait_done(0, BUDGET, n);
      check("after_reset_done", n, 1);
      check("after_reset_frame_count", mon_cnt(0) - base, FL);
      check_frame("after_reset", 0, base, vecs[1].ms, vecs[1].d2);

      // Zero-gap and long-gap instances.
      base = mon_cnt(1);
      start_frame(1, vecs[1].ms, vecs[1].d2);
      wait_done(1, BUDGET, n);
      check("gap0_done", n, 1);
      check("gap0_byte_count", mon_cnt(1) - base, FL);
      check_frame("gap0", 1, base, vecs[1].ms, vecs[1].d2);

      base = mon_cnt(2);
      start_frame(2, vecs[3].ms, vecs[3].d2);
      wait_done(2, BUDGET_H, n);
      check("gap100_done", n, 1);
      check("gap100_byte_count", mon_cnt(2) - base, FL);
      check_frame("gap100", 2, base, vecs[3].ms, vecs[3].d2);
      check("gap100_min_idle_ok", longint'(g_mon[2].min_idle >= 100), 1);

      check("framing_errors", g_mon[0].ferr + g_mon[1].ferr + g_mon[2].ferr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
